// File: rtl/mhz1_bus_ctrl_pkg.sv
// Shared BBC definitions for the 1 MHz bus: slow-space decode ranges and the
// access-controller state type.
package mhz1_bus_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_e;

    // FRED/JIM pages, then the slow SHEILA windows (CRTC/ACIA, serial ULA, VIAs, ADC)
    localparam logic [15:0] FREDJIM_LO  = 16'hFC00;
    localparam logic [15:0] FREDJIM_HI  = 16'hFDFF;
    localparam logic [15:0] SHEILA0_LO  = 16'hFE00;
    localparam logic [15:0] SHEILA0_HI  = 16'hFE1F;
    localparam logic [15:0] SHEILA1_LO  = 16'hFE40;
    localparam logic [15:0] SHEILA1_HI  = 16'hFE7F;
    localparam logic [15:0] SHEILA2_LO  = 16'hFEC0;
    localparam logic [15:0] SHEILA2_HI  = 16'hFEDF;

    function automatic logic is_slow_addr(input logic [15:0] addr);
        return (addr >= FREDJIM_LO && addr <= FREDJIM_HI) ||
               (addr >= SHEILA0_LO && addr <= SHEILA0_HI) ||
               (addr >= SHEILA1_LO && addr <= SHEILA1_HI) ||
               (addr >= SHEILA2_LO && addr <= SHEILA2_HI);
    endfunction

endpackage

// File: rtl/mhz1_bus_ctrl_if.sv
// CPU-side and peripheral-side signals of the 1 MHz bus controller.
// master = CPU/clock-generator/peripheral side, slave = the controller.
interface mhz1_bus_ctrl_if;
    logic        cpu_clken;
    logic        mhz2_clken;
    logic        mhz1_clken;
    logic [15:0] cpu_addr;
    logic        cpu_rnw;
    logic [7:0]  cpu_dout;
    logic [7:0]  slow_din;
    logic        mhz1_enable;
    logic        slow_cs;
    logic        slow_rnw;
    logic [15:0] slow_addr;
    logic [7:0]  slow_wdata;
    logic        slow_wr_stb;
    logic [7:0]  slow_rdata;
    logic        slow_done;

    modport master (
        output cpu_clken, mhz2_clken, mhz1_clken, cpu_addr, cpu_rnw, cpu_dout, slow_din,
        input  mhz1_enable, slow_cs, slow_rnw, slow_addr, slow_wdata, slow_wr_stb,
               slow_rdata, slow_done
    );

    modport slave (
        input  cpu_clken, mhz2_clken, mhz1_clken, cpu_addr, cpu_rnw, cpu_dout, slow_din,
        output mhz1_enable, slow_cs, slow_rnw, slow_addr, slow_wdata, slow_wr_stb,
               slow_rdata, slow_done
    );
endinterface

// File: rtl/mhz1_bus_ctrl.sv
// 1 MHz peripheral bus controller: decodes slow-space CPU accesses, requests
// cycle stretching and runs one aligned 1 MHz peripheral cycle per access.
module mhz1_bus_ctrl
    import mhz1_bus_ctrl_pkg::*;
(
    input  logic            clk_48m,
    input  logic            reset_n,
    mhz1_bus_ctrl_if.slave  bus
);

    state_e      state_q;
    logic        cs_q;
    logic        rnw_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        wr_stb_q;
    logic [7:0]  rdata_q;
    logic        done_q;
    logic        hit;

    assign hit = is_slow_addr(bus.cpu_addr);

    // Gated by IDLE so HOLD suppresses a second stretch for the same CPU cycle
    assign bus.mhz1_enable = hit && (state_q == IDLE);

    always_ff @(posedge clk_48m) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cs_q     <= 1'b0;
            rnw_q    <= 1'b1;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            wr_stb_q <= 1'b0;
            rdata_q  <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            wr_stb_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.mhz2_clken && hit) begin
                        addr_q  <= bus.cpu_addr;
                        rnw_q   <= bus.cpu_rnw;
                        wdata_q <= bus.cpu_dout;
                        cs_q    <= 1'b1;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Entry happens on the edge that samples mhz2, so any mhz1 seen
                    // here is strictly after entry.
                    if (bus.mhz1_clken) begin
                        done_q   <= 1'b1;
                        wr_stb_q <= !rnw_q;
                        if (rnw_q)
                            rdata_q <= bus.slow_din;
                        cs_q     <= 1'b0;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.cpu_clken)
                        state_q <= IDLE;
                end
                default: begin
                    cs_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.slow_cs     = cs_q;
    assign bus.slow_rnw    = rnw_q;
    assign bus.slow_addr   = addr_q;
    assign bus.slow_wdata  = wdata_q;
    assign bus.slow_wr_stb = wr_stb_q;
    assign bus.slow_rdata  = rdata_q;
    assign bus.slow_done   = done_q;

endmodule

// File: tb/tb_mhz1_bus_ctrl.sv
// Directed bench for mhz1_bus_ctrl: frame-position stimulus, a transaction-level
// timing model checked every cycle, and literal checks on the key results.
module tb_mhz1_bus_ctrl;

    logic clk_48m = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    mhz1_bus_ctrl_if bus();

    mhz1_bus_ctrl dut (
        .clk_48m (clk_48m),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clk_48m = ~clk_48m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic bit slow_hit(input logic [15:0] a);
        int v;
        v = int'(a);
        if (v < 'hFC00) return 0;
        if (v < 'hFE00) return 1;
        if (v >= 'hFF00) return 0;
        // SHEILA: 32-byte blocks 0,2,3,6 are slow
        case ((v - 'hFE00) / 32)
            0, 2, 3, 6: return 1;
            default:    return 0;
        endcase
    endfunction

    // Advance one clock; frame enables follow directly from position in the 48-clock frame.
    task automatic step();
        int p;
        @(posedge clk_48m);
        #1;
        cyc++;
        p = cyc % 48;
        bus.cpu_clken  = (p == 0) || (p == 24);
        bus.mhz2_clken = (p == 23) || (p == 47);
        bus.mhz1_clken = (p == 47);
    endtask

    task automatic goto_pos(input int p);
        step();
        while (cyc % 48 != p) step();
    endtask

    // Model: an accepted access is a window of cycles ending at the next position 47.
    bit          m_act = 0;
    int          m_acc, m_comp;
    logic        m_rnw = 1'b1;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0, m_rdata = '0, m_din_cap = '0;
    int          done_cnt = 0, wr_cnt = 0, cs_cnt = 0;
    logic [15:0] last_wr_addr = '0;
    logic [7:0]  last_wr_data = '0;

    always @(negedge clk_48m) begin
        bit e_idle, e_cs, e_done;
        if (cyc >= 1) begin
            e_idle = !m_act || (cyc > m_comp + 1);
            e_cs   = m_act && cyc > m_acc && cyc <= m_comp;
            e_done = m_act && cyc == m_comp + 1;
            if (e_done && m_rnw) m_rdata = m_din_cap;
            check("mhz1_enable", 32'(bus.mhz1_enable), 32'(e_idle && slow_hit(bus.cpu_addr)));
            check("slow_cs",     32'(bus.slow_cs),     32'(e_cs));
            check("slow_done",   32'(bus.slow_done),   32'(e_done));
            check("slow_wr_stb", 32'(bus.slow_wr_stb), 32'(e_done && !m_rnw));
            check("slow_rnw",    32'(bus.slow_rnw),    32'(m_rnw));
            check("slow_addr",   32'(bus.slow_addr),   32'(m_addr));
            check("slow_wdata",  32'(bus.slow_wdata),  32'(m_wdata));
            check("slow_rdata",  32'(bus.slow_rdata),  32'(m_rdata));
            if (bus.slow_done === 1'b1) done_cnt++;
            if (bus.slow_cs === 1'b1) cs_cnt++;
            if (bus.slow_wr_stb === 1'b1) begin
                wr_cnt++;
                last_wr_addr = bus.slow_addr;
                last_wr_data = bus.slow_wdata;
            end
            if (m_act && cyc == m_comp) m_din_cap = bus.slow_din;
            if (!reset_n) begin
                m_act = 0; m_rnw = 1'b1; m_addr = '0; m_wdata = '0; m_rdata = '0;
            end else if (e_idle && bus.mhz2_clken && slow_hit(bus.cpu_addr)) begin
                m_act   = 1;
                m_acc   = cyc;
                m_comp  = cyc + ((cyc % 48 == 47) ? 48 : 24);
                m_addr  = bus.cpu_addr;
                m_rnw   = bus.cpu_rnw;
                m_wdata = bus.cpu_dout;
            end else if (e_idle) begin
                m_act = 0;
            end
        end
    end

    initial begin
        int d0, w0, c0;
        bus.cpu_clken = 1'b1; bus.mhz2_clken = 1'b0; bus.mhz1_clken = 1'b0;
        bus.cpu_addr = 16'h8000; bus.cpu_rnw = 1'b1; bus.cpu_dout = 8'h00; bus.slow_din = 8'h00;
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        check("reset cs", 32'(bus.slow_cs), 32'h0);
        check("reset rnw", 32'(bus.slow_rnw), 32'h1);

        // Read 0xFE40 sampled at position 23: 24-clock window
        goto_pos(1);
        d0 = done_cnt; w0 = wr_cnt; c0 = cs_cnt;
        bus.cpu_addr = 16'hFE40; bus.cpu_rnw = 1'b1; bus.slow_din = 8'h5A;
        goto_pos(1);
        bus.cpu_addr = 16'h8000;
        check("t1 rdata", 32'(bus.slow_rdata), 32'h5A);
        check("t1 done count", 32'(done_cnt - d0), 32'd1);
        check("t1 no wr", 32'(wr_cnt - w0), 32'd0);
        check("t1 cs clocks", 32'(cs_cnt - c0), 32'd24);

        // Write 0xFC12/0xA5 sampled at position 47: 48-clock window
        goto_pos(25);
        d0 = done_cnt; w0 = wr_cnt; c0 = cs_cnt;
        bus.cpu_addr = 16'hFC12; bus.cpu_rnw = 1'b0; bus.cpu_dout = 8'hA5;
        goto_pos(1);
        goto_pos(1);
        bus.cpu_addr = 16'h8000; bus.cpu_rnw = 1'b1;
        check("t2 wr count", 32'(wr_cnt - w0), 32'd1);
        check("t2 wr addr", 32'(last_wr_addr), 32'hFC12);
        check("t2 wr data", 32'(last_wr_data), 32'hA5);
        check("t2 cs clocks", 32'(cs_cnt - c0), 32'd48);

        // Non-slow SHEILA holes never start an access
        c0 = cs_cnt;
        bus.cpu_addr = 16'hFE30;
        goto_pos(1);
        bus.cpu_addr = 16'hFEE0;
        goto_pos(1);
        bus.cpu_addr = 16'h8000;
        check("t3 no cs", 32'(cs_cnt - c0), 32'd0);

        // 0xFE00 held into HOLD: exactly one completion
        d0 = done_cnt;
        bus.cpu_addr = 16'hFE00; bus.slow_din = 8'h3C;
        goto_pos(1);
        bus.cpu_addr = 16'h8000;
        step();
        check("t4 done count", 32'(done_cnt - d0), 32'd1);
        check("t4 rdata", 32'(bus.slow_rdata), 32'h3C);

        // Reset 10 clocks into an ACTIVE write
        goto_pos(1);
        w0 = wr_cnt;
        bus.cpu_addr = 16'hFD00; bus.cpu_rnw = 1'b0; bus.cpu_dout = 8'h77;
        goto_pos(34);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus.cpu_addr = 16'h8000; bus.cpu_rnw = 1'b1;
        check("t5 cs", 32'(bus.slow_cs), 32'h0);
        check("t5 addr", 32'(bus.slow_addr), 32'h0);
        check("t5 wdata", 32'(bus.slow_wdata), 32'h0);
        check("t5 rnw", 32'(bus.slow_rnw), 32'h1);
        check("t5 rdata", 32'(bus.slow_rdata), 32'h0);
        goto_pos(1);
        check("t5 no wr", 32'(wr_cnt - w0), 32'd0);

        // Back-to-back reads 0xFE41 then 0xFEC0
        d0 = done_cnt;
        bus.cpu_addr = 16'hFE41; bus.slow_din = 8'h11;
        goto_pos(1);
        bus.cpu_addr = 16'hFEC0; bus.slow_din = 8'h22;
        goto_pos(20);
        check("t6 rdata held", 32'(bus.slow_rdata), 32'h11);
        goto_pos(1);
        bus.cpu_addr = 16'h8000;
        check("t6 rdata second", 32'(bus.slow_rdata), 32'h22);
        check("t6 done count", 32'(done_cnt - d0), 32'd2);

        goto_pos(1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mhz1_bus_ctrl.md
# mhz1_bus_ctrl

Decodes CPU accesses to the BBC 1 MHz peripheral space, requests CPU cycle stretching from the clock-enable generator, and runs one aligned 1 MHz peripheral cycle per access. Sits between the CPU address/data bus and the slow peripherals (CRTC, ACIA, serial ULA, VIAs, ADC, FRED, JIM). Presents latched address, write data and chip-select to the peripherals, and returns latched read data to the CPU data mux.

## Interface
- No parameters. Decode ranges are fixed constants in the shared package.
- Reset is reset_n, synchronous, active-low; clock is clk_48m.
- clk_48m  in  1  system clock, 48 MHz
- reset_n  in  1  synchronous active-low reset
- cpu_clken  in  1  CPU cycle enable (48-clock frame positions 0/24, possibly masked)
- mhz2_clken  in  1  pulse at frame positions 23/47
- mhz1_clken  in  1  pulse at frame position 47
- cpu_addr  in  16  CPU address, stable from the clock after cpu_clken
- cpu_rnw  in  1  1 = read
- cpu_dout  in  8  CPU write data
- slow_din  in  8  peripheral read data (OR of selected peripheral outputs)
- mhz1_enable  out  1  combinational stretch request to clock generator
- slow_cs  out  1  1 MHz peripheral cycle active
- slow_rnw  out  1  latched cpu_rnw
- slow_addr  out  16  latched cpu_addr
- slow_wdata  out  8  latched cpu_dout
- slow_wr_stb  out  1  one-clock write strobe at cycle completion
- slow_rdata  out  8  read data latched at completion, held until next completion
- slow_done  out  1  one-clock pulse at completion (read or write)

## Operation
- Decode, hit = slow space: 0xFC00–0xFDFF, 0xFE00–0xFE1F, 0xFE40–0xFE7F, 0xFEC0–0xFEDF. Not slow: 0xFE20–0xFE3F, 0xFE80–0xFEBF, 0xFEE0–0xFEFF, all other addresses.
- mhz1_enable = hit(cpu_addr) AND state is IDLE. Combinational, so the generator samples it on its mhz2_clken.
- FSM states: IDLE, ACTIVE, HOLD.
- IDLE: on mhz2_clken with hit, latch slow_addr, slow_rnw and slow_wdata, then go to ACTIVE.
- ACTIVE: slow_cs=1. On mhz1_clken (the first one strictly after entry):
  - pulse slow_done;
  - pulse slow_wr_stb if slow_rnw=0;
  - if slow_rnw=1, load slow_rdata from slow_din;
  - go to HOLD.
- Same-clock case: a hit sampled on a mhz2_clken that is also mhz1_clken (position 47) enters ACTIVE and completes on the next position 47, giving a 48-clock window. A hit at position 23 completes at position 47, giving a 24-clock window.
- HOLD: slow_cs=0 and mhz1_enable forced 0. Go to IDLE on cpu_clken. This stops the still-present address from re-triggering before the CPU advances.
- slow_addr, slow_rnw and slow_wdata change only on IDLE→ACTIVE.

## Timing
- Reset values: state IDLE; slow_cs, slow_wr_stb, slow_done = 0; slow_rnw = 1; slow_addr, slow_wdata, slow_rdata = 0.
- Reset mid-ACTIVE: no strobe or done is issued, slow_rdata is unchanged at 0 after reset, and the FSM returns to IDLE next clock.
- slow_cs rises 1 clock after the sampling mhz2_clken. It falls 1 clock after the completing mhz1_clken.
- slow_wr_stb and slow_done are registered. They are high for exactly the clock after the completing mhz1_clken (frame position 0), which coincides with the released cpu_clken.
- slow_rdata is valid from frame position 0 after completion, in time for the CPU read at that cpu_clken.
- A non-hit mhz2_clken in IDLE has no effect. mhz2_clken in ACTIVE or HOLD is ignored.

## Structure
- The shared BBC package holds:
  - slow-space range constants;
  - the function is_slow_addr(addr[15:0]);
  - the state enum {IDLE, ACTIVE, HOLD}.
- No sub-module: the decode is a package function and the FSM plus latches form a single block.

## Test plan
- Read 0xFE40, hit sampled at position 23, slow_din=0x5A → slow_cs high 24 clocks; slow_done at position 0; slow_rdata=0x5A; no slow_wr_stb.
- Write 0xFC12 data 0xA5, hit at position 47 → slow_cs high 48 clocks; slow_wr_stb once with slow_addr=0xFC12, slow_wdata=0xA5.
- Access 0xFE30 and 0xFEE0 → mhz1_enable stays 0; slow_cs stays 0; FSM stays IDLE.
- Address 0xFE00 held through HOLD until cpu_clken → mhz1_enable=0 in HOLD; exactly one slow_done.
- reset_n=0 at position 10 of an ACTIVE write → no slow_wr_stb; all outputs at reset values next clock.
- Back-to-back reads 0xFE41 then 0xFEC0 → two slow_done pulses; slow_rdata updates on each; slow_rdata holds between them.
